// File: rtl/acc_read_sequencer_pkg.sv
// Shared types and constants for the accumulator read path: bank geometry,
// read modes, sequencer states and the per-bank address bundle.
package acc_read_sequencer_pkg;

   localparam int ACC_BANKS  = 32;
   localparam int ACC_ADDR_W = 7;
   localparam int ACC_DEPTH  = 128;
   // Wide enough for the longest DIAG sequence: 128 + 32 - 1 = 159 steps.
   localparam int ACC_STEP_W = 8;

   typedef enum logic {
      NORMAL = 1'b0,
      DIAG   = 1'b1
   } acc_rd_mode;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } acc_seq_state_t;

   typedef logic [ACC_BANKS-1:0][ACC_ADDR_W-1:0] diag_addr_array_t;

   function automatic logic [ACC_STEP_W-1:0] acc_clamp_rows(input logic [ACC_ADDR_W:0] n);
      return (n > (ACC_ADDR_W+1)'(ACC_DEPTH)) ? ACC_STEP_W'(ACC_DEPTH) : ACC_STEP_W'(n);
   endfunction

   function automatic logic [ACC_STEP_W-1:0] acc_total_steps(input acc_rd_mode m,
                                                             input logic [ACC_STEP_W-1:0] rows);
      return (m == DIAG) ? rows + ACC_STEP_W'(ACC_BANKS - 1) : rows;
   endfunction

endpackage

// File: rtl/acc_read_sequencer_if.sv
// Control and bank-read bundle between the sequencer (master), the control FSM
// and the accumulator read ports (slave side).
interface acc_read_sequencer_if;
   import acc_read_sequencer_pkg::*;

   logic                          start_i;
   acc_rd_mode                    mode_i;
   logic [ACC_ADDR_W-1:0]         base_addr_i;
   logic [ACC_ADDR_W:0]           num_rows_i;
   logic                          stall_i;
   logic                          busy_o;
   logic                          done_o;
   logic [ACC_BANKS-1:0]          rd_en_o;
   diag_addr_array_t              rd_addr_o;
   logic                          rd_last_o;

   modport master (
      input  start_i, mode_i, base_addr_i, num_rows_i, stall_i,
      output busy_o, done_o, rd_en_o, rd_addr_o, rd_last_o
   );

   modport slave (
      output start_i, mode_i, base_addr_i, num_rows_i, stall_i,
      input  busy_o, done_o, rd_en_o, rd_addr_o, rd_last_o
   );

endinterface

// File: rtl/acc_read_sequencer_diag_addr_gen.sv
// Combinational per-bank enable/address for one issue step; NORMAL reads one row
// everywhere, DIAG delays bank j by j steps and parks idle banks at address 0.
module acc_diag_addr_gen
   import acc_read_sequencer_pkg::*;
(
   input  logic [ACC_STEP_W-1:0]  step_i,
   input  logic [ACC_ADDR_W-1:0]  base_i,
   input  logic [ACC_STEP_W-1:0]  rows_i,
   input  acc_rd_mode             mode_i,
   output logic [ACC_BANKS-1:0]   en_o,
   output diag_addr_array_t       addr_o
);

   always_comb begin
      en_o   = '0;
      addr_o = '0;
      for (int j = 0; j < ACC_BANKS; j++) begin
         if (mode_i == NORMAL) begin
            en_o[j]   = 1'b1;
            addr_o[j] = base_i + step_i[ACC_ADDR_W-1:0];
         end else if ((step_i >= ACC_STEP_W'(j)) &&
                      ((step_i - ACC_STEP_W'(j)) < rows_i)) begin
            // 7-bit truncation gives the modulo-DEPTH wrap for free.
            en_o[j]   = 1'b1;
            addr_o[j] = base_i + step_i[ACC_ADDR_W-1:0] - ACC_ADDR_W'(j);
         end
      end
   end

endmodule

// File: rtl/acc_read_sequencer.sv
// Accumulator read sequencer: step 0 registered in the cycle after start, one step per cycle.
// A stall sampled at an edge blanks the next cycle's enables and holds the step; done follows rd_last.
module acc_read_sequencer
   import acc_read_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   acc_read_sequencer_if.master  bus
);

   acc_seq_state_t          state_q;
   logic [ACC_STEP_W-1:0]   step_q;
   acc_rd_mode              mode_q;
   logic [ACC_ADDR_W-1:0]   base_q;
   logic [ACC_STEP_W-1:0]   rows_q;

   logic                    busy_q;
   logic                    done_q;
   logic [ACC_BANKS-1:0]    rd_en_q;
   diag_addr_array_t        rd_addr_q;
   logic                    rd_last_q;

   logic [ACC_STEP_W-1:0]   rows_d;
   logic                    issuing;
   logic [ACC_STEP_W-1:0]   gen_step;
   logic [ACC_ADDR_W-1:0]   gen_base;
   logic [ACC_STEP_W-1:0]   gen_rows;
   acc_rd_mode              gen_mode;
   logic                    gen_last;
   logic [ACC_BANKS-1:0]    gen_en;
   diag_addr_array_t        gen_addr;

   // Outside ISSUE the generator looks at the live start parameters so step 0
   // can be registered on the very edge that accepts start.
   assign rows_d   = acc_clamp_rows(bus.num_rows_i);
   assign issuing  = (state_q == ISSUE);
   assign gen_step = issuing ? step_q : '0;
   assign gen_base = issuing ? base_q : bus.base_addr_i;
   assign gen_rows = issuing ? rows_q : rows_d;
   assign gen_mode = issuing ? mode_q : bus.mode_i;
   assign gen_last = (gen_step == (acc_total_steps(gen_mode, gen_rows) - ACC_STEP_W'(1)));

   acc_diag_addr_gen u_addr_gen (
      .step_i (gen_step),
      .base_i (gen_base),
      .rows_i (gen_rows),
      .mode_i (gen_mode),
      .en_o   (gen_en),
      .addr_o (gen_addr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         step_q    <= '0;
         mode_q    <= NORMAL;
         base_q    <= '0;
         rows_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= '0;
         rd_addr_q <= '0;
         rd_last_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_q   <= IDLE;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               rd_en_q   <= '0;
               rd_last_q <= 1'b0;
               if (bus.start_i) begin
                  mode_q <= bus.mode_i;
                  base_q <= bus.base_addr_i;
                  rows_q <= rows_d;
                  if (rows_d == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= ISSUE;
                     busy_q    <= 1'b1;
                     rd_en_q   <= gen_en;
                     rd_addr_q <= gen_addr;
                     rd_last_q <= gen_last;
                     step_q    <= ACC_STEP_W'(1);
                  end
               end
            end
            ISSUE: begin
               if (rd_last_q) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  rd_en_q   <= '0;
                  rd_last_q <= 1'b0;
               end else if (bus.stall_i) begin
                  rd_en_q   <= '0;
                  rd_last_q <= 1'b0;
               end else begin
                  rd_en_q   <= gen_en;
                  rd_addr_q <= gen_addr;
                  rd_last_q <= gen_last;
                  step_q    <= step_q + ACC_STEP_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.rd_en_o   = rd_en_q;
   assign bus.rd_addr_o = rd_addr_q;
   assign bus.rd_last_o = rd_last_q;

endmodule

// File: tb/tb_acc_read_sequencer.sv
// Bench for acc_read_sequencer: directed table, corner sequences and random
// traffic, all checked every cycle against a step-list reference model.
module tb_acc_read_sequencer;
   import acc_read_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   acc_read_sequencer_if ifc();

   acc_read_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a sequence is a list of steps 0..S-1; each unstalled cycle
   // presents the next step, and the cycle after the last step is the done pulse.
   bit                     m_active = 0;
   int                     m_next = 0, m_S = 0, m_base = 0, m_rows = 0;
   acc_rd_mode             m_mode = NORMAL;
   bit                     m_busy = 0, m_done = 0, m_last = 0;
   bit [ACC_BANKS-1:0]     m_en = '0;
   bit [ACC_BANKS-1:0][ACC_ADDR_W-1:0] m_addr = '0;

   task automatic emit(input int s);
      for (int j = 0; j < ACC_BANKS; j++) begin
         if (m_mode == NORMAL) begin
            m_en[j]   = 1'b1;
            m_addr[j] = 7'((m_base + s) % ACC_DEPTH);
         end else if (j <= s && s < j + m_rows) begin
            m_en[j]   = 1'b1;
            m_addr[j] = 7'((m_base + s - j) % ACC_DEPTH);
         end else begin
            m_en[j]   = 1'b0;
            m_addr[j] = '0;
         end
      end
      m_busy = 1;
      m_last = (s == m_S - 1);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_busy = 0; m_done = 0; m_last = 0; m_en = '0; m_addr = '0; m_next = 0;
      end else if (m_active) begin
         if (m_last) begin
            m_active = 0; m_busy = 0; m_done = 1; m_en = '0; m_last = 0;
         end else if (ifc.stall_i) begin
            m_en = '0; m_last = 0;
         end else begin
            emit(m_next);
            m_next++;
         end
      end else begin
         m_done = 0; m_busy = 0; m_en = '0; m_last = 0;
         if (ifc.start_i) begin
            m_mode = ifc.mode_i;
            m_base = int'(ifc.base_addr_i);
            m_rows = (int'(ifc.num_rows_i) > ACC_DEPTH) ? ACC_DEPTH : int'(ifc.num_rows_i);
            m_S    = (m_mode == DIAG) ? m_rows + ACC_BANKS - 1 : m_rows;
            if (m_rows == 0) begin
               m_done = 1;
            end else begin
               m_active = 1;
               emit(0);
               m_next = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("bg_busy", 256'(ifc.busy_o), 256'(m_busy));
      chk("bg_done", 256'(ifc.done_o), 256'(m_done));
      chk("bg_rd_en", 256'(ifc.rd_en_o), 256'(m_en));
      chk("bg_rd_addr", 256'(ifc.rd_addr_o), 256'(m_addr));
      chk("bg_rd_last", 256'(ifc.rd_last_o), 256'(m_last));
   end

   task automatic do_start(input acc_rd_mode md, input int base, input int rows);
      @(negedge clk);
      ifc.start_i     = 1'b1;
      ifc.mode_i      = md;
      ifc.base_addr_i = 7'(base);
      ifc.num_rows_i  = 8'(rows);
      @(negedge clk);
      ifc.start_i     = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      for (k = 0; k < 400; k++) begin
         if (!ifc.busy_o && !ifc.done_o) break;
         @(negedge clk);
      end
      if (k == 400) begin
         n_vec++; n_err++;
         $display("FAIL wait_idle: busy_o still %0b after 400 cycles, required 0", ifc.busy_o);
      end
   endtask

   typedef struct {
      acc_rd_mode mode;
      int         base;
      int         rows;
      int         step;
      int         bank;
      bit         exp_en;
      int         exp_addr;
      bit         exp_last;
   } vec_t;

   vec_t vt[13];

   initial begin
      int cnt, dones;
      ifc.start_i = 0; ifc.mode_i = NORMAL; ifc.base_addr_i = '0;
      ifc.num_rows_i = '0; ifc.stall_i = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 256'(ifc.busy_o), 256'(0));
      chk("rst_rd_en", 256'(ifc.rd_en_o), 256'(0));
      chk("rst_rd_addr", 256'(ifc.rd_addr_o), 256'(0));
      rst_n = 1'b1;

      vt[0]  = '{NORMAL,   0,   4,   0,  5, 1'b1,   0, 1'b0};
      vt[1]  = '{NORMAL,   0,   4,   3, 31, 1'b1,   3, 1'b1};
      vt[2]  = '{DIAG,    10,   2,   0,  0, 1'b1,  10, 1'b0};
      vt[3]  = '{DIAG,    10,   2,   0,  1, 1'b0,   0, 1'b0};
      vt[4]  = '{DIAG,    10,   2,   1,  0, 1'b1,  11, 1'b0};
      vt[5]  = '{DIAG,    10,   2,   1,  1, 1'b1,  10, 1'b0};
      vt[6]  = '{DIAG,    10,   2,  31, 30, 1'b1,  11, 1'b0};
      vt[7]  = '{DIAG,    10,   2,  31, 31, 1'b1,  10, 1'b0};
      vt[8]  = '{DIAG,    10,   2,  31, 29, 1'b0,   0, 1'b0};
      vt[9]  = '{DIAG,    10,   2,  32, 31, 1'b1,  11, 1'b1};
      vt[10] = '{NORMAL, 126,   4,   2,  7, 1'b1,   0, 1'b0};
      vt[11] = '{NORMAL, 126,   4,   3,  0, 1'b1,   1, 1'b1};
      vt[12] = '{NORMAL,   5, 200, 127,  3, 1'b1,   4, 1'b1};

      for (int i = 0; i < 13; i++) begin
         do_start(vt[i].mode, vt[i].base, vt[i].rows);
         repeat (vt[i].step) @(negedge clk);
         chk($sformatf("vec%0d_en", i), 256'(ifc.rd_en_o[vt[i].bank]), 256'(vt[i].exp_en));
         chk($sformatf("vec%0d_addr", i), 256'(ifc.rd_addr_o[vt[i].bank]), 256'(vt[i].exp_addr));
         chk($sformatf("vec%0d_last", i), 256'(ifc.rd_last_o), 256'(vt[i].exp_last));
         @(negedge clk);
         wait_idle();
      end

      // rows=0: done pulses in the first cycle after start, nothing issued
      do_start(DIAG, 3, 0);
      chk("rows0_done", 256'(ifc.done_o), 256'(1));
      chk("rows0_en", 256'(ifc.rd_en_o), 256'(0));
      chk("rows0_busy", 256'(ifc.busy_o), 256'(0));
      @(negedge clk);
      wait_idle();

      // start during ISSUE must not disturb the running sequence
      do_start(NORMAL, 0, 8);
      cnt = 1;
      repeat (2) begin @(negedge clk); cnt++; end
      ifc.start_i = 1'b1; ifc.mode_i = DIAG; ifc.num_rows_i = 8'd0;
      @(negedge clk); cnt++;
      ifc.start_i = 1'b0;
      for (int k = 0; k < 50 && !ifc.done_o; k++) begin
         @(negedge clk);
         if (ifc.rd_en_o != '0) cnt++;
      end
      chk("ignore_start_steps", 256'(cnt), 256'(8));
      @(negedge clk);
      wait_idle();

      // DIAG with a two-cycle stall after step 1
      do_start(DIAG, 20, 3);
      cnt = 1;
      @(negedge clk); cnt++;
      ifc.stall_i = 1'b1;
      @(negedge clk); cnt++;
      chk("stall1_en", 256'(ifc.rd_en_o), 256'(0));
      chk("stall1_addr0", 256'(ifc.rd_addr_o[0]), 256'(21));
      @(negedge clk); cnt++;
      chk("stall2_en", 256'(ifc.rd_en_o), 256'(0));
      chk("stall2_addr1", 256'(ifc.rd_addr_o[1]), 256'(20));
      ifc.stall_i = 1'b0;
      @(negedge clk); cnt++;
      chk("resume_addr0", 256'(ifc.rd_addr_o[0]), 256'(22));
      chk("resume_addr2", 256'(ifc.rd_addr_o[2]), 256'(20));
      chk("resume_en", 256'(ifc.rd_en_o), 256'(32'h7));
      for (int k = 0; k < 100 && !ifc.done_o; k++) begin
         @(negedge clk); cnt++;
      end
      chk("stall_latency", 256'(cnt), 256'(37));
      @(negedge clk);
      wait_idle();

      // asynchronous reset at DIAG step 5
      do_start(DIAG, 40, 10);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 256'(ifc.busy_o), 256'(0));
      chk("arst_en", 256'(ifc.rd_en_o), 256'(0));
      chk("arst_addr", 256'(ifc.rd_addr_o), 256'(0));
      chk("arst_last", 256'(ifc.rd_last_o), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (ifc.done_o || ifc.busy_o) dones++;
      end
      chk("arst_no_done", 256'(dones), 256'(0));

      // back-to-back: start in the done cycle
      do_start(NORMAL, 60, 2);
      for (int k = 0; k < 10 && !ifc.done_o; k++) @(negedge clk);
      ifc.start_i = 1'b1; ifc.mode_i = NORMAL; ifc.base_addr_i = 7'd90; ifc.num_rows_i = 8'd3;
      @(negedge clk);
      ifc.start_i = 1'b0;
      chk("b2b_en", 256'(ifc.rd_en_o), 256'(32'hFFFF_FFFF));
      chk("b2b_addr", 256'(ifc.rd_addr_o[17]), 256'(90));
      chk("b2b_busy", 256'(ifc.busy_o), 256'(1));
      @(negedge clk);
      wait_idle();

      // random traffic checked by the background model
      for (int it = 0; it < 30; it++) begin
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            ifc.start_i     = ($urandom_range(0, 19) == 0);
            ifc.mode_i      = $urandom_range(0, 1) ? DIAG : NORMAL;
            ifc.base_addr_i = 7'($urandom_range(0, 127));
            ifc.num_rows_i  = 8'($urandom_range(0, 140));
            ifc.stall_i     = ($urandom_range(0, 3) == 0);
         end
      end
      @(negedge clk);
      ifc.start_i = 1'b0;
      ifc.stall_i = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
